// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings
// and the alignment rule used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store data shift and strobes for the
// outgoing request, and extract/extend of returning load data.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      st_size,
  input  logic [2:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_lane_data,
  output logic [7:0]      st_strb,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [2:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_value
);

  logic [XLEN-1:0] st_masked;
  logic [7:0]      st_base;
  logic [XLEN-1:0] ld_shifted;

  // Store: keep only the bytes of the access size, then move them to their lanes.
  always_comb begin
    st_base   = 8'hFF;
    st_masked = st_data;
    case (st_size)
      SZ_B: begin st_base = 8'h01; st_masked = {{(XLEN-8){1'b0}},  st_data[7:0]};  end
      SZ_H: begin st_base = 8'h03; st_masked = {{(XLEN-16){1'b0}}, st_data[15:0]}; end
      SZ_W: begin st_base = 8'h0F; st_masked = {{(XLEN-32){1'b0}}, st_data[31:0]}; end
      default: ;
    endcase
    st_lane_data = st_masked << {st_off, 3'b000};
    st_strb      = st_base << st_off;
  end

  // Load: bring the addressed byte lane down to bit 0, then truncate and extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B: ld_value = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                   : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H: ld_value = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                   : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W: ld_value = ld_unsigned ? {{(XLEN-32){1'b0}}, ld_shifted[31:0]}
                                   : {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_value = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time from execute, issues a
// single data-memory access and writes load results back to the register file.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_load_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wstrb_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            reg_wen_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            misalign_o,
  output logic            busy_o
);

  state_t          state;
  logic            load;
  logic [1:0]      size;
  logic            unsigned_ld;
  logic [2:0]      off;
  logic [4:0]      rd;
  logic [XLEN-1:0] st_lane_data;
  logic [7:0]      st_strb;
  logic [XLEN-1:0] ld_value;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size      (req_size_i),
    .st_off       (req_addr_i[2:0]),
    .st_data      (req_wdata_i),
    .st_lane_data (st_lane_data),
    .st_strb      (st_strb),
    .ld_size      (size),
    .ld_unsigned  (unsigned_ld),
    .ld_off       (off),
    .ld_rdata     (mem_rdata_i),
    .ld_value     (ld_value)
  );

  assign req_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);

  // Request FSM; every memory and register-file output is a register so it is clean off the flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      load        <= 1'b0;
      size        <= SZ_B;
      unsigned_ld <= 1'b0;
      off         <= 3'd0;
      rd          <= 5'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= 8'h00;
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= 5'd0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (is_misaligned(req_size_i, req_addr_i[2:0])) begin
              misalign_o <= 1'b1;
            end else begin
              state       <= S_REQ;
              load        <= req_load_i;
              size        <= req_size_i;
              unsigned_ld <= req_unsigned_i;
              off         <= req_addr_i[2:0];
              rd          <= req_rd_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= ~req_load_i;
              mem_addr_o  <= {req_addr_i[XLEN-1:3], 3'b000};
              mem_wdata_o <= req_load_i ? '0 : st_lane_data;
              mem_wstrb_o <= req_load_i ? 8'h00 : st_strb;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            state       <= load ? S_WAIT : S_IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= 8'h00;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state       <= S_WB;
            reg_wen_o   <= (rd != 5'd0);
            reg_waddr_o <= rd;
            reg_wdata_o <= ld_value;
          end
        end
        S_WB: begin
          state       <= S_IDLE;
          reg_wen_o   <= 1'b0;
          reg_waddr_o <= 5'd0;
          reg_wdata_o <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: XLEN, default 64, data/address width; only 64 is supported.
REQ-002 clk_i  in  1  sole clock; all state on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_i / req_ready_o  in / out  1 / 1  execute-stage request handshake; transfer when both high.
REQ-005 req_load_i  in  1  1 = load, 0 = store.
REQ-006 req_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-007 req_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU); ignored for stores and doubles.
REQ-008 req_addr_i, req_wdata_i  in  64 each  byte address; store data in low bits.
REQ-009 req_rd_i  in  5  load destination register.
REQ-010 mem_req_o, mem_we_o  out  1 each  data-memory request; write enable.
REQ-011 mem_addr_o  out  64  doubleword-aligned address (low 3 bits zero).
REQ-012 mem_wdata_o, mem_wstrb_o  out  64, 8  lane-shifted store data; byte strobes.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1, 1, 64  request accepted; read data valid; read data.
REQ-014 reg_wen_o, reg_waddr_o, reg_wdata_o  out  1, 5, 64  register-file write port.
REQ-015 misalign_o  out  1  one-cycle pulse on misaligned request; busy_o  out  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, REQ, WAIT, WB.
REQ-017 req_ready_o is high only in IDLE; all request fields are registered on transfer.
REQ-018 Misalignment check: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
REQ-019 Misaligned transfer: misalign_o pulses the following cycle, no memory request, no register write, state stays IDLE.
REQ-020 Aligned transfer in cycle N: IDLE->REQ, with mem_req_o high from cycle N+1.
REQ-021 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o are held stable in REQ until mem_gnt_i.
REQ-022 Store with mem_gnt_i: REQ->IDLE; no register write.
REQ-023 Load with mem_gnt_i: REQ->WAIT.
REQ-024 Store lanes: data is shifted left by 8*addr[2:0]; strobes are 1/3/15/255 shifted left by addr[2:0].
REQ-025 Load strobes are 0 and mem_we_o is 0.
REQ-026 mem_rvalid_i is sampled only in WAIT and is ignored in every other state.
REQ-027 In WAIT, mem_rvalid_i captures mem_rdata_i and the state goes to WB.
REQ-028 Load extract: field = rdata >> 8*addr[2:0], truncated to size, then sign- or zero-extended to 64 bits.
REQ-029 WB lasts exactly one cycle: reg_wen_o=1, reg_waddr_o=rd, reg_wdata_o=extracted value; then WB->IDLE.
REQ-030 reg_wen_o stays 0 when rd=0; the access still occurs.
REQ-031 reg_wen_o is 0 outside WB; reg_waddr_o/reg_wdata_o are 0 outside WB.
REQ-032 Minimum load latency: transfer cycle N, gnt at N+1, rvalid at N+2, write at N+3.
REQ-033 A new request is not accepted in the WB cycle; it is accepted in the next IDLE cycle.

Reset
REQ-034 rst_n_i low forces IDLE immediately, regardless of clock.
REQ-035 During reset, all mem_* and reg_* outputs, misalign_o and busy_o are 0; req_ready_o is 1.
REQ-036 Reset during REQ or WAIT abandons the operation: no register write, and a stale rvalid after release is ignored.

Structure
REQ-037 Package lsu_pkg holds the state enum and the size encodings (SZ_B, SZ_H, SZ_W, SZ_D).
REQ-038 Combinational sub-module lsu_align performs store lane shift, strobe generation and load extract/extend.
REQ-039 The FSM and request registers are in lsu.

Verification
REQ-040 LD 0x1000, rd=5, gnt after 2 cycles, rdata 0x1122334455667788 -> single reg_wen_o pulse, waddr 5, wdata 0x1122334455667788.
REQ-041 LB 0x1003, rdata 0x0000000080000000 -> wdata 0xFFFFFFFFFFFFFF80; the same access as LBU -> 0x0000000000000080.
REQ-042 SW 0x2004, wdata 0xDEADBEEF -> mem_addr 0x2000, wstrb 0xF0, mem_wdata[63:32]=0xDEADBEEF, no reg write.
REQ-043 LH 0x1001 -> misalign_o one cycle, mem_req_o never high, req_ready_o high next cycle.
REQ-044 Load, then reset asserted in WAIT, then rvalid one cycle after release -> reg_wen_o stays 0 and state is IDLE.
REQ-045 LW 0x3000, rd=0 -> mem_req_o/gnt handshake completes, reg_wen_o stays 0, busy_o falls after the WB cycle.
